rr_dec_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among 8 requesters.
- Picks a winner index and drives a one-hot grant through an enabled 3-to-8 decode stage.
- Sits in front of any shared combinational/peripheral resource addressed by a 3-bit select with enable.
- Provides fair rotation, grant hold until release, and a global enable.

---
 rtl/arb_pkg.sv | 13 +
 rtl/onehot_dec3to8.sv | 13 +
 rtl/rr_dec_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_dec_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the round-robin decode arbiter: requester count,
// index width, FSM state encoding and the default grant hold limit.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/onehot_dec3to8.sv
// Enabled 3-to-8 one-hot decoder; output is all-zero while en is low.
module onehot_dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y = 8'h01 << sel;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant.
// Define ARB_TIMEOUT_EN to add the forced-release hold counter (MAX_HOLD).
//
// Handshake: req[i] is a level request. Once gnt[i] is high it stays high
// until the holder drops req[i] or pulses done for one cycle; the grant
// then clears on the next edge, followed by exactly one idle cycle.
module rr_dec_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return p + off;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] winner;
  logic             normal_rel;
  logic             force_rel;
  logic             in_grant;

  assign winner     = rr_pick(req, ptr_q);
  assign in_grant   = (state_q == ST_GRANT);
  assign normal_rel = done | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  assign force_rel = (hold_cnt_q == HOLD_LIM);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    if (!in_grant) begin
      if (en && (req != '0)) hold_cnt_d = 8'h00;
    end else if (normal_rel || force_rel) begin
      timeout_d = force_rel & ~normal_rel;
    end else begin
      hold_cnt_d = hold_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (en && (req != '0)) begin
          state_d     = ST_GRANT;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        // en is deliberately ignored here: a holder keeps its grant.
        if (normal_rel || force_rel) begin
          state_d     = ST_IDLE;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

  onehot_dec3to8 u_dec (
    .sel (gnt_idx_q),
    .en  (gnt_valid_q),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed self-checking bench for rr_dec_arbiter; define ARB_TIMEOUT_EN
// to also exercise forced release with MAX_HOLD=4.
module tb_rr_dec_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int failures;

`ifdef ARB_TIMEOUT_EN
  rr_dec_arbiter #(.MAX_HOLD(4)) dut (
`else
  rr_dec_arbiter dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, "_vld"}, 32'(gnt_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt0"}, 32'(gnt), 32'd0);
    check({tag, "_vld0"}, 32'(gnt_valid), 32'd0);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (3) tick();

    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_vld", 32'(gnt_valid), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single request, one-cycle latency, hold, release via done
    en  = 1'b1;
    req = 8'h01;
    tick();
    check_grant("single", 3'd0);
    tick();
    tick();
    check_grant("single_hold", 3'd0);
    req = 8'h00;
    pulse_done();
    check_idle("single_rel");
    check("single_idx_kept", 32'(gnt_idx), 32'd0);
    check("single_ptr", 32'(dut.ptr_q), 32'd1);

    // done while idle has no effect
    pulse_done();
    check_idle("done_idle");
    check("done_idle_ptr", 32'(dut.ptr_q), 32'd1);

    // full rotation from ptr=1 with all requesting
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_grant($sformatf("rot%0d", k), 3'((1 + k) % 8));
      pulse_done();
      check_idle($sformatf("rot%0d_gap", k));
    end
    req = 8'h00;
    tick();
    check_idle("rot_end");
    check("rot_ptr", 32'(dut.ptr_q), 32'd2);

    // get ptr to 3, then fairness skip 3..6 to requester 7, wrap to 0
    req = 8'h04;
    tick();
    check_grant("pre_skip", 3'd2);
    req = 8'h81;
    pulse_done();
    check_idle("pre_skip_rel");
    check("skip_ptr", 32'(dut.ptr_q), 32'd3);
    tick();
    check_grant("skip7", 3'd7);
    pulse_done();
    check_idle("skip7_rel");
    check("skip_ptr0", 32'(dut.ptr_q), 32'd0);
    tick();
    check_grant("skip0", 3'd0);
    req = 8'h00;
    pulse_done();
    check_idle("skip0_rel");

    // enable gating and en dropped mid-grant
    en  = 1'b0;
    req = 8'h10;
    repeat (3) tick();
    check_idle("en_off");
    en = 1'b1;
    tick();
    check_grant("en_on", 3'd4);
    en = 1'b0;
    tick();
    tick();
    check_grant("en_drop_hold", 3'd4);
    pulse_done();
    check_idle("en_drop_rel");
    tick();
    tick();
    check_idle("en_drop_nonew");
    en  = 1'b1;
    req = 8'h00;
    tick();

    // long hold on requester 5 (ptr=5)
    req = 8'h20;
    tick();
    check_grant("hold1", 3'd5);
`ifdef ARB_TIMEOUT_EN
    check("hold1_tmo", 32'(timeout), 32'd0);
    repeat (3) tick();
    check_grant("hold4", 3'd5);
    check("hold4_tmo", 32'(timeout), 32'd0);
    tick();
    check_idle("tmo_rel");
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_ptr", 32'(dut.ptr_q), 32'd6);
    tick();
    check_grant("tmo_regrant", 3'd5);
    check("tmo_clear", 32'(timeout), 32'd0);
`else
    repeat (20) tick();
    check_grant("hold_long", 3'd5);
    check("hold_tmo", 32'(timeout), 32'd0);
`endif
    req = 8'h00;
    tick();
    check_idle("hold_rel");

    // asynchronous reset in the middle of a grant
    req = 8'h04;
    tick();
    check_grant("mid_rst_pre", 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_vld", 32'(gnt_valid), 32'd0);
    check("mid_rst_ptr", 32'(dut.ptr_q), 32'd0);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h04;
    tick();
    check_grant("post_rst", 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
